// File: rtl/rvvi_trace_pkg.sv
// Shared types and constants for the RVVI retire-record token encoder.
package rvvi_trace_pkg;

  typedef enum logic [3:0] {
    KEY_ORDER = 4'd0,
    KEY_INSN  = 4'd1,
    KEY_PC    = 4'd2,
    KEY_MODE  = 4'd3,
    KEY_TRAP  = 4'd4,
    KEY_X     = 4'd5,
    KEY_F     = 4'd6,
    KEY_CSR   = 4'd7,
    KEY_END   = 4'd15
  } token_key_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_XREG,
    S_FREG,
    S_CSR,
    S_END
  } enc_state_t;

  localparam int HDR_TOKENS = 5;

endpackage

// File: rtl/rvvi_lsb_pick.sv
// Combinational 32-bit find-first-set: reports whether any bit is set and the lowest set index.
module rvvi_lsb_pick (
  input  logic [31:0] vec,
  output logic        found,
  output logic [4:0]  idx
);

  // Scan from the top so the last hit wins, leaving the lowest set bit.
  always_comb begin
    found = 1'b0;
    idx   = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/rvvi_trace_encoder.sv
// Serializes one RVVI retire record into {key, idx, data} tokens.
// Optional FP register tokens are enabled by defining RVVI_TRACE_FREG_EN.
module rvvi_trace_encoder
  import rvvi_trace_pkg::*;
#(
  parameter  int XLEN   = 64,
  parameter  int FLEN   = 64,
  localparam int DATA_W = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         order,
  input  logic [31:0]         insn,
  input  logic                trap,
  input  logic [XLEN-1:0]     pc_rdata,
  input  logic [1:0]          mode,
  input  logic [31:0]         x_wb,
  input  logic [32*XLEN-1:0]  x_wdata,
`ifdef RVVI_TRACE_FREG_EN
  input  logic [31:0]         f_wb,
  input  logic [32*FLEN-1:0]  f_wdata,
`endif
  input  logic                csr_wb,
  input  logic [11:0]         csr_addr,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output token_key_t          out_key,
  output logic [11:0]         out_idx,
  output logic [DATA_W-1:0]   out_data
);

  enc_state_t          state;
  logic [2:0]          hdr_cnt;
  logic [31:0]         insn_q;
  logic                trap_q;
  logic [XLEN-1:0]     pc_q;
  logic [1:0]          mode_q;
  logic [31:0]         x_mask;
  logic [32*XLEN-1:0]  x_data_q;
  logic                csr_pend;
  logic [11:0]         csr_addr_q;
  logic [XLEN-1:0]     csr_data_q;

  logic                x_found;
  logic [4:0]          x_idx;

  enc_state_t          nxt_state;
  logic                nxt_valid;
  token_key_t          nxt_key;
  logic [11:0]         nxt_idx;
  logic [DATA_W-1:0]   nxt_data;
  logic [2:0]          nxt_hdr;
  logic [31:0]         nxt_x;
  logic                nxt_csr;
  logic [DATA_W-1:0]   hdr_data;

  rvvi_lsb_pick u_x_pick (.vec(x_mask), .found(x_found), .idx(x_idx));

`ifdef RVVI_TRACE_FREG_EN
  logic [31:0]         f_mask;
  logic [32*FLEN-1:0]  f_data_q;
  logic                f_found;
  logic [4:0]          f_idx;
  logic [31:0]         nxt_f;

  rvvi_lsb_pick u_f_pick (.vec(f_mask), .found(f_found), .idx(f_idx));
`endif

  assign in_ready = (state == S_IDLE) && !reset;

  // ORDER is loaded straight from the inputs at capture, so hdr_cnt starts at INSN.
  always_comb begin
    case (hdr_cnt)
      3'd1:    hdr_data = DATA_W'(insn_q);
      3'd2:    hdr_data = DATA_W'(pc_q);
      3'd3:    hdr_data = DATA_W'(mode_q);
      default: hdr_data = DATA_W'(trap_q);
    endcase
  end

  // Token to present after the current one transfers; empty sections fall through in the same cycle.
  always_comb begin
    nxt_state = S_IDLE;
    nxt_valid = 1'b0;
    nxt_key   = KEY_END;
    nxt_idx   = '0;
    nxt_data  = '0;
    nxt_hdr   = hdr_cnt;
    nxt_x     = x_mask;
    nxt_csr   = csr_pend;
`ifdef RVVI_TRACE_FREG_EN
    nxt_f     = f_mask;
`endif
    if (state == S_HDR && hdr_cnt < 3'(HDR_TOKENS)) begin
      nxt_state = S_HDR;
      nxt_valid = 1'b1;
      nxt_key   = token_key_t'({1'b0, hdr_cnt});
      nxt_data  = hdr_data;
      nxt_hdr   = hdr_cnt + 3'd1;
    end else if (x_found) begin
      nxt_state = S_XREG;
      nxt_valid = 1'b1;
      nxt_key   = KEY_X;
      nxt_idx   = 12'(x_idx);
      nxt_data  = DATA_W'(x_data_q[x_idx*XLEN +: XLEN]);
      nxt_x     = x_mask & ~(32'd1 << x_idx);
    end
`ifdef RVVI_TRACE_FREG_EN
    else if (f_found) begin
      nxt_state = S_FREG;
      nxt_valid = 1'b1;
      nxt_key   = KEY_F;
      nxt_idx   = 12'(f_idx);
      nxt_data  = DATA_W'(f_data_q[f_idx*FLEN +: FLEN]);
      nxt_f     = f_mask & ~(32'd1 << f_idx);
    end
`endif
    else if (csr_pend) begin
      nxt_state = S_CSR;
      nxt_valid = 1'b1;
      nxt_key   = KEY_CSR;
      nxt_idx   = csr_addr_q;
      nxt_data  = DATA_W'(csr_data_q);
      nxt_csr   = 1'b0;
    end else if (state != S_END) begin
      nxt_state = S_END;
      nxt_valid = 1'b1;
      nxt_key   = KEY_END;
    end
  end

  // A trapped record keeps only header and END, so its write masks are dropped at capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hdr_cnt   <= 3'd0;
      out_valid <= 1'b0;
      out_key   <= KEY_ORDER;
      out_idx   <= '0;
      out_data  <= '0;
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        state      <= S_HDR;
        hdr_cnt    <= 3'd1;
        out_valid  <= 1'b1;
        out_key    <= KEY_ORDER;
        out_idx    <= '0;
        out_data   <= DATA_W'(order);
        insn_q     <= insn;
        trap_q     <= trap;
        pc_q       <= pc_rdata;
        mode_q     <= mode;
        x_mask     <= trap ? 32'd0 : (x_wb & ~32'd1);
        x_data_q   <= x_wdata;
        csr_pend   <= csr_wb && !trap;
        csr_addr_q <= csr_addr;
        csr_data_q <= csr_wdata;
`ifdef RVVI_TRACE_FREG_EN
        f_mask     <= trap ? 32'd0 : f_wb;
        f_data_q   <= f_wdata;
`endif
      end
    end else if (out_ready) begin
      state     <= nxt_state;
      hdr_cnt   <= nxt_hdr;
      x_mask    <= nxt_x;
      csr_pend  <= nxt_csr;
`ifdef RVVI_TRACE_FREG_EN
      f_mask    <= nxt_f;
`endif
      out_valid <= nxt_valid;
      out_key   <= nxt_key;
      out_idx   <= nxt_idx;
      out_data  <= nxt_data;
    end
  end

endmodule

// File: tb/tb_rvvi_trace_encoder.sv
// Self-checking bench for rvvi_trace_encoder: table vectors, corner sequences and random records.
module tb_rvvi_trace_encoder;
  import rvvi_trace_pkg::*;

  localparam int XLEN = 64;
  localparam int FLEN = 64;

  typedef struct {
    logic [3:0]  key;
    logic [11:0] idx;
    logic [63:0] data;
  } tok_t;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic [63:0] pc;
    logic [1:0]  mode;
    logic        trap;
    logic [31:0] x_wb;
    logic [63:0] x5;
    logic [31:0] f_wb;
    logic        csr_wb;
    logic [11:0] csr_addr;
    int          ready_mode;
    int          exp_nof;
    int          exp_f;
  } vec_t;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        order;
  logic [31:0]        insn;
  logic               trap;
  logic [XLEN-1:0]    pc_rdata;
  logic [1:0]         mode;
  logic [31:0]        x_wb;
  logic [32*XLEN-1:0] x_wdata;
  logic [31:0]        f_wb;
  logic [32*FLEN-1:0] f_wdata;
  logic               csr_wb;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_key;
  logic [11:0]        out_idx;
  logic [63:0]        out_data;

  logic [63:0] xdat [32];
  logic [63:0] fdat [32];
  tok_t        expq [$];
  vec_t        tbl  [6];
  int          n_checks = 0;
  int          n_fail   = 0;

  rvvi_trace_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .order(order), .insn(insn), .trap(trap), .pc_rdata(pc_rdata), .mode(mode),
    .x_wb(x_wb), .x_wdata(x_wdata),
`ifdef RVVI_TRACE_FREG_EN
    .f_wb(f_wb), .f_wdata(f_wdata),
`endif
    .csr_wb(csr_wb), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .out_idx(out_idx), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected token list derived directly from the record contents.
  task automatic buildExpected();
    expq.delete();
    expq.push_back('{4'(KEY_ORDER), 12'd0, order});
    expq.push_back('{4'(KEY_INSN),  12'd0, 64'(insn)});
    expq.push_back('{4'(KEY_PC),    12'd0, 64'(pc_rdata)});
    expq.push_back('{4'(KEY_MODE),  12'd0, 64'(mode)});
    expq.push_back('{4'(KEY_TRAP),  12'd0, 64'(trap)});
    if (!trap) begin
      for (int i = 1; i < 32; i++)
        if (x_wb[i]) expq.push_back('{4'(KEY_X), 12'(i), xdat[i]});
`ifdef RVVI_TRACE_FREG_EN
      for (int i = 0; i < 32; i++)
        if (f_wb[i]) expq.push_back('{4'(KEY_F), 12'(i), fdat[i]});
`endif
      if (csr_wb) expq.push_back('{4'(KEY_CSR), csr_addr, 64'(csr_wdata)});
    end
    expq.push_back('{4'(KEY_END), 12'd0, 64'd0});
  endtask

  task automatic packData();
    for (int i = 0; i < 32; i++) begin
      x_wdata[i*XLEN +: XLEN] = xdat[i];
      f_wdata[i*FLEN +: FLEN] = fdat[i];
    end
  endtask

  task automatic applyStimulus();
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("in_ready_before_capture", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Drains one record: mode 0 = always ready, 1 = random ready, 2 = stall cycles 1..3.
  task automatic collect(input int rmode, output int got, output int iters);
    logic        stalled = 1'b0;
    logic [3:0]  hk = '0;
    logic [11:0] hi = '0;
    logic [63:0] hd = '0;
    tok_t        t;
    got = 0;
    iters = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 1 && cyc <= 3);
      endcase
      @(negedge clk);
      if (stalled) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_key",   64'(out_key),   64'(hk));
        checkOutput("hold_idx",   64'(out_idx),   64'(hi));
        checkOutput("hold_data",  out_data,       hd);
      end
      if (expq.size() == 0) begin
        checkOutput("idle_valid_after_end", 64'(out_valid), 64'd0);
        checkOutput("in_ready_after_end",   64'(in_ready),  64'd1);
        break;
      end
      iters++;
      if (out_valid && out_ready) begin
        t = expq.pop_front();
        checkOutput($sformatf("tok%0d_key", got),  64'(out_key), 64'(t.key));
        checkOutput($sformatf("tok%0d_idx", got),  64'(out_idx), 64'(t.idx));
        checkOutput($sformatf("tok%0d_data", got), out_data,     t.data);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        hk = out_key;
        hi = out_idx;
        hd = out_data;
      end
      @(posedge clk); #1;
    end
    if (expq.size() != 0) begin
      checkOutput("drain_timeout_remaining", 64'(expq.size()), 64'd0);
      expq.delete();
    end
  endtask

  task automatic loadVec(input vec_t v);
    order = v.order; insn = v.insn; pc_rdata = v.pc; mode = v.mode; trap = v.trap;
    x_wb = v.x_wb; f_wb = v.f_wb; csr_wb = v.csr_wb; csr_addr = v.csr_addr;
    csr_wdata = {$urandom, $urandom};
    for (int i = 0; i < 32; i++) begin
      xdat[i] = {$urandom, $urandom};
      fdat[i] = {$urandom, $urandom};
    end
    xdat[5] = v.x5;
    fdat[0] = 64'h3FF0_0000_0000_0000;
    packData();
  endtask

  initial begin
    int got, iters, exp_n, found;
    tbl[0] = '{order:64'd1, insn:32'h0070_0293, pc:64'h8000_0000, mode:2'd3, trap:1'b0,
               x_wb:32'h20, x5:64'h7, f_wb:32'h0, csr_wb:1'b0, csr_addr:12'h0,
               ready_mode:0, exp_nof:7, exp_f:7};
    tbl[1] = '{order:64'd2, insn:32'h0020_80b3, pc:64'h8000_0004, mode:2'd0, trap:1'b0,
               x_wb:32'h8000_0006, x5:64'h0, f_wb:32'h0, csr_wb:1'b0, csr_addr:12'h0,
               ready_mode:0, exp_nof:9, exp_f:9};
    tbl[2] = '{order:64'd3, insn:32'h0000_0013, pc:64'h8000_0008, mode:2'd1, trap:1'b0,
               x_wb:32'h1, x5:64'h0, f_wb:32'h0, csr_wb:1'b0, csr_addr:12'h0,
               ready_mode:0, exp_nof:6, exp_f:6};
    tbl[3] = '{order:64'd4, insn:32'h0000_0073, pc:64'h8000_000C, mode:2'd3, trap:1'b1,
               x_wb:32'h2, x5:64'h0, f_wb:32'h0, csr_wb:1'b1, csr_addr:12'h341,
               ready_mode:0, exp_nof:6, exp_f:6};
    tbl[4] = '{order:64'd5, insn:32'h0010_1073, pc:64'h8000_0010, mode:2'd3, trap:1'b0,
               x_wb:32'h0, x5:64'h0, f_wb:32'h1, csr_wb:1'b1, csr_addr:12'h001,
               ready_mode:0, exp_nof:7, exp_f:8};
    tbl[5] = '{order:64'd6, insn:32'h0070_0293, pc:64'h8000_0014, mode:2'd3, trap:1'b0,
               x_wb:32'h20, x5:64'h7, f_wb:32'h0, csr_wb:1'b0, csr_addr:12'h0,
               ready_mode:2, exp_nof:7, exp_f:7};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    loadVec(tbl[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd0);
    checkOutput("reset_out_key",   64'(out_key),   64'd0);
    checkOutput("reset_out_idx",   64'(out_idx),   64'd0);
    checkOutput("reset_out_data",  out_data,       64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      loadVec(tbl[v]);
      buildExpected();
`ifdef RVVI_TRACE_FREG_EN
      exp_n = tbl[v].exp_f;
`else
      exp_n = tbl[v].exp_nof;
`endif
      applyStimulus();
      collect(tbl[v].ready_mode, got, iters);
      checkOutput($sformatf("vec%0d_token_count", v), 64'(got), 64'(exp_n));
      if (tbl[v].ready_mode == 0)
        checkOutput($sformatf("vec%0d_cycles", v), 64'(iters), 64'(exp_n));
    end

    // Reset while X tokens are streaming, then a fresh record.
    loadVec(tbl[1]);
    x_wb = 32'h0000_00F0;
    applyStimulus();
    out_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (out_valid && out_key == 4'(KEY_X)) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("reached_xreg", 64'(found), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_in_ready",  64'(in_ready),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postreset_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    loadVec(tbl[0]);
    buildExpected();
    applyStimulus();
    collect(0, got, iters);
    checkOutput("postreset_token_count", 64'(got), 64'd7);

    // Random records under random back-pressure.
    for (int r = 0; r < 25; r++) begin
      order = {$urandom, $urandom}; insn = $urandom; pc_rdata = {$urandom, $urandom};
      mode = 2'($urandom_range(0, 3)); trap = ($urandom_range(0, 5) == 0);
      x_wb = $urandom & $urandom; f_wb = $urandom & $urandom & $urandom;
      csr_wb = 1'($urandom_range(0, 1)); csr_addr = 12'($urandom);
      csr_wdata = {$urandom, $urandom};
      for (int i = 0; i < 32; i++) begin
        xdat[i] = {$urandom, $urandom};
        fdat[i] = {$urandom, $urandom};
      end
      packData();
      buildExpected();
      exp_n = 6;
      if (!trap) begin
        exp_n += $countones(x_wb & ~32'd1) + int'(csr_wb);
`ifdef RVVI_TRACE_FREG_EN
        exp_n += $countones(f_wb);
`endif
      end
      applyStimulus();
      collect(1, got, iters);
      checkOutput($sformatf("rand%0d_token_count", r), 64'(got), 64'(exp_n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
